// File: rtl/xor_oper_if.sv
// ---------------------------------------------------------------------------
// xor_oper_if : operand/result bundle for the registered XOR stage.
//
// Signals
//   a   operand A (driven by master)
//   b   operand B (driven by master)
//   co  registered a ^ b (driven by slave)
//
// Handshake: there is none. The pipeline advances on every rising clock
// edge; a new operand pair is consumed each cycle and co always holds the
// result of the pair sampled LATENCY edges earlier (or 0 after reset).
// ---------------------------------------------------------------------------
interface xor_oper_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] co;

  modport master (output a, output b, input co);
  modport slave  (input a, input b, output co);
endinterface

// File: rtl/xor_oper.sv
// ---------------------------------------------------------------------------
// xor_oper : bitwise XOR of two operands through a LATENCY-deep register
// pipeline.
//
// Parameters
//   WIDTH    operand/result width (>= 1); must match the bus WIDTH
//   LATENCY  number of register stages between inputs and co (>= 1)
//
// Ports
//   clk   system clock, all state updates on the rising edge
//   rstn  synchronous active-low reset; clears every stage to 0
//   bus   xor_oper_if slave: a, b in; co out (last pipeline stage)
//
// co is driven only by the final register, so there is no combinational
// path from a/b to co. Reset has priority over data capture.
// ---------------------------------------------------------------------------
module xor_oper #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input logic       clk,
  input logic       rstn,
  xor_oper_if.slave bus
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("xor_oper: WIDTH must be >= 1");
    end

    if (LATENCY < 1) begin : g_bad_latency
      // A zero-stage pipeline would make co combinational; refuse it.
      $error("xor_oper: LATENCY must be >= 1");
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [LATENCY];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          // Discard every in-flight result so co reads 0, never stale data.
          for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= bus.a ^ bus.b;
          for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign bus.co = stage_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_xor_oper.sv
// ---------------------------------------------------------------------------
// tb_xor_oper : drives two xor_oper instances (4-bit/latency 1 and
// 8-bit/latency 3) from one linear sequence of directed and random steps.
// Expected co values come from a history-based model: the result seen after
// edge N is the XOR sampled at edge N-LATENCY+1, or 0 if any edge in that
// window had rstn low.
// ---------------------------------------------------------------------------
module tb_xor_oper;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  xor_oper_if #(.WIDTH(4)) bus4 ();
  xor_oper_if #(.WIDTH(8)) bus8 ();

  xor_oper #(.WIDTH(4), .LATENCY(1)) dut4 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus4)
  );

  xor_oper #(.WIDTH(8), .LATENCY(3)) dut8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus8)
  );

  // ---------------- reference model ----------------
  // One entry per rising edge: was reset asserted, and the XOR presented.
  bit         rst_q[$];
  logic [7:0] x4_q[$];
  logic [7:0] x8_q[$];

  always @(posedge clk) begin
    rst_q.push_back(!rstn);
    x4_q.push_back({4'b0000, bus4.a ^ bus4.b});
    x8_q.push_back(bus8.a ^ bus8.b);
  end

  // which: 0 -> 4-bit/latency-1 DUT, 1 -> 8-bit/latency-3 DUT
  function automatic logic [7:0] model(input int which);
    int lat;
    int n;
    int m;
    lat = (which == 0) ? 1 : 3;
    n   = rst_q.size() - 1;
    m   = n - lat + 1;
    for (int k = (m < 0 ? 0 : m); k <= n; k++) begin
      if (rst_q[k]) return 8'h00;
    end
    if (m < 0) return 8'hxx;
    return (which == 0) ? x4_q[m] : x8_q[m];
  endfunction

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: co=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model comparison for both DUTs (skipped only while the model is undefined).
  task automatic check_model(input string tag);
    logic [7:0] e4;
    logic [7:0] e8;
    e4 = model(0);
    e8 = model(1);
    if (!$isunknown(e4)) check({tag, "/m4"}, {4'b0000, bus4.co}, e4);
    if (!$isunknown(e8)) check({tag, "/m8"}, bus8.co, e8);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive4(input logic [3:0] a, input logic [3:0] b);
    bus4.a = a;
    bus4.b = b;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b);
    bus8.a = a;
    bus8.b = b;
  endtask

  // One rising edge, then sample on the falling edge and compare to model.
  task automatic tick(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] held4;
    logic [7:0] held8;

    // Reset hold: 2 edges with a=F, b=0.
    rstn = 1'b0;
    drive4(4'hF, 4'h0);
    drive8(8'hA5, 8'hFF);
    tick("rst_edge1");
    check("rst_edge1_co4", {4'b0000, bus4.co}, 8'h00);
    check("rst_edge1_co8", bus8.co, 8'h00);
    tick("rst_edge2");
    check("rst_edge2_co4", {4'b0000, bus4.co}, 8'h00);

    // Release; 4-bit result one edge later, 8-bit needs three edges.
    rstn = 1'b1;
    tick("release1");
    check("release1_co4", {4'b0000, bus4.co}, 8'h0F);
    check("release1_co8", bus8.co, 8'h00);
    tick("release2");
    check("release2_co8", bus8.co, 8'h00);
    tick("release3");
    check("sweep_co8", bus8.co, 8'h5A);

    // Stream.
    drive4(4'b1111, 4'b1001);
    tick("stream1");
    check("stream1_co4", {4'b0000, bus4.co}, 8'h06);
    drive4(4'b0110, 4'b1001);
    tick("stream2");
    check("stream2_co4", {4'b0000, bus4.co}, 8'h0F);
    drive4(4'b1000, 4'b1001);
    tick("stream3");
    check("stream3_co4", {4'b0000, bus4.co}, 8'h01);

    // Zero and identity.
    drive4(4'b0000, 4'b0000);
    tick("zero");
    check("zero_co4", {4'b0000, bus4.co}, 8'h00);
    drive4(4'b1010, 4'b1010);
    tick("ident");
    check("ident_co4", {4'b0000, bus4.co}, 8'h00);
    drive4(4'b0101, 4'b0000);
    tick("pass");
    check("pass_co4", {4'b0000, bus4.co}, 8'h05);

    // Mid-stream reset pulse.
    drive4(4'b1111, 4'b1001);
    drive8(8'h3C, 8'h0F);
    tick("pre_rst");
    rstn = 1'b0;
    tick("mid_rst");
    check("mid_rst_co4", {4'b0000, bus4.co}, 8'h00);
    check("mid_rst_co8", bus8.co, 8'h00);
    rstn = 1'b1;
    tick("mid_rel1");
    check("mid_rel1_co4", {4'b0000, bus4.co}, 8'h06);
    check("mid_rel1_co8", bus8.co, 8'h00);
    tick("mid_rel2");
    tick("mid_rel3");
    check("mid_rel3_co8", bus8.co, 8'h33);

    // Hold: constant inputs for 10 cycles.
    drive4(4'b0110, 4'b1001);
    for (int i = 0; i < 10; i++) begin
      tick("hold");
      check("hold_co4", {4'b0000, bus4.co}, 8'h0F);
    end

    // Random stream with occasional reset; inputs also wiggle between edges.
    for (int i = 0; i < 80; i++) begin
      rstn = ($urandom_range(0, 9) != 0);
      drive4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      tick("rand");
      held4 = {4'b0000, bus4.co};
      held8 = bus8.co;
      drive4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      #2;
      check("between_edges_co4", {4'b0000, bus4.co}, held4);
      check("between_edges_co8", bus8.co, held8);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/xor_oper.md
Name: xor_oper

Overview:
- Registered bitwise-XOR stage: co is the XOR of operands a and b, captured on the clock edge.
- Used as a small pipelined datapath primitive. Inputs come from synchronous stimulus or upstream logic; the output is a registered value suitable for direct downstream consumption.
- Latency is configurable through a pipeline-depth parameter.

Parameters:
- WIDTH, 4, bit width of a, b and co (must be >= 1).
- LATENCY, 1, number of register stages between the inputs and co (must be >= 1; 0 is illegal and must trigger an elaboration-time error).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous and active-low.
- a  input  WIDTH  operand A, sampled on the rising edge of clk.
- b  input  WIDTH  operand B, sampled on the rising edge of clk.
- co  output  WIDTH  registered result a ^ b, delayed by LATENCY clock cycles.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Port names are clk and rstn.
- Reset:
  - On a rising edge of clk with rstn==0, every pipeline stage clears to 0, so co==0 in the cycle after that edge.
  - Reset takes effect only on clock edges; rstn has no asynchronous path.
  - Before the first reset edge, co is undefined.
- Function:
  - Stage 1 captures a ^ b, bitwise across all WIDTH bits, on each rising edge with rstn==1.
  - Each subsequent stage copies the previous stage.
  - co is driven directly by the last stage. There is no combinational path from a or b to co.
- Latency:
  - Inputs sampled at edge N appear on co after edge N+LATENCY-1 has completed.
  - With LATENCY=1, co updates at the same edge that samples a and b, and is visible one cycle after the inputs are presented.
- Throughput: one new operand pair accepted every cycle. No handshake, no stall, no valid signal; the pipeline always advances.
- Arithmetic: pure bitwise XOR with no carry. Output width equals input width, so no truncation or extension occurs.
- Hold behaviour: if a and b stay constant, co stays constant once the pipeline has filled.
- Reset mid-stream:
  - A reset edge discards all in-flight results; every stage becomes 0.
  - After rstn returns to 1, the first valid result appears LATENCY edges later.
  - Meanwhile co shows 0 rather than stale data.
- Simultaneous events: when rstn==0 at an edge, reset wins over data capture.
- Input changes between clock edges have no effect on co.
- The design must be synthesizable, use no latches, and contain no initial blocks or clock gating.

Test Plan:
- Reset: hold rstn=0 for 2 edges with a=4'hF, b=4'h0 -> co==4'b0000 after the first reset edge. Release rstn and keep inputs -> co==4'b1111 one edge later (LATENCY=1).
- Stream: with rstn=1, apply a=1111,b=1001 at edge 1; a=0110,b=1001 at edge 2; a=1000,b=1001 at edge 3 (inputs set just after each edge). co must read 0110, then 1111, then 0001 on successive cycles.
- Zero and identity: a=0000,b=0000 -> co=0000. a=1010,b=1010 -> co=0000. a=0101,b=0000 -> co=0101.
- Mid-stream reset: stream 1111^1001 and pulse rstn=0 for one edge -> co==0000 for that cycle. Then co resumes the XOR result of current inputs on the next edge.
- Parameter sweep: WIDTH=8, LATENCY=3, a=8'hA5, b=8'hFF -> co==8'h5A exactly 3 edges after sampling; co==0 for those cycles after reset.
- Hold: keep a=0110,b=1001 constant for 10 cycles -> co stays at 1111 with no glitches at any clock edge.
